// File: rtl/bsg_print_stat_tracker_pkg.sv
// Shared types for the print_stat interval tracker.
// Tag kind encoding, field widths and the output record layout.
package bsg_print_stat_tracker_pkg;

   typedef enum logic [1:0] {
      K_STAT  = 2'b00,
      K_START = 2'b01,
      K_END   = 2'b10,
      K_RSVD  = 2'b11
   } tag_kind_e;

   // kind occupies the top bits of the tag
   localparam int kind_width_lp = 2;

   function automatic int tag_id_width(input int els);
      return (els > 1) ? $clog2(els) : 1;
   endfunction

endpackage

`ifndef BSG_PRINT_STAT_REC_S
`define BSG_PRINT_STAT_REC_S(ctr_w, id_w) \
   struct packed { \
      tag_kind_e        kind; \
      logic [id_w-1:0]  id; \
      logic [ctr_w-1:0] start; \
      logic [ctr_w-1:0] delta; \
   }
`endif

// File: rtl/bsg_fifo_1r1w_small.sv
// Small flop-based FIFO, valid/ready in, valid/yumi out.
// A full FIFO still accepts a push when a pop happens the same cycle.
module bsg_fifo_1r1w_small #(
   parameter int width_p = 8,
   parameter int els_p   = 8
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               v_i,
   output logic               ready_o,
   input  logic [width_p-1:0] data_i,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cnt_w_lp = $clog2(els_p + 1);

   logic [ptr_w_lp-1:0] wptr_r, rptr_r;
   logic [cnt_w_lp-1:0] cnt_r;
   logic [width_p-1:0]  mem_r [els_p];
   logic                full, push, pop;

   function automatic logic [ptr_w_lp-1:0] nxt(input logic [ptr_w_lp-1:0] p);
      return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (cnt_r == cnt_w_lp'(els_p));
   assign v_o     = (cnt_r != '0);
   assign ready_o = ~full | yumi_i;
   assign push    = v_i & ready_o;
   assign pop     = yumi_i & v_o;
   assign data_o  = mem_r[rptr_r];

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wptr_r <= '0;
         rptr_r <= '0;
         cnt_r  <= '0;
      end else begin
         if (push) wptr_r <= nxt(wptr_r);
         if (pop)  rptr_r <= nxt(rptr_r);
         if (push & ~pop)      cnt_r <= cnt_r + 1'b1;
         else if (pop & ~push) cnt_r <= cnt_r - 1'b1;
      end
   end

   // storage needs no reset; occupancy gates its visibility
   always_ff @(posedge clk_i) begin
      if (push) mem_r[wptr_r] <= data_i;
   end

endmodule

// File: rtl/bsg_print_stat_interval_tracker.sv
// Pairs print_stat START/END tags per id and emits interval records.
// Define BSG_PRINT_STAT_TRACKER_DISPLAY_EN for sim-only record/error prints.
module bsg_print_stat_interval_tracker
   import bsg_print_stat_tracker_pkg::*;
#(
   parameter  int data_width_p = 32,
   parameter  int ctr_width_p  = 64,
   parameter  int tag_els_p    = 16,
   parameter  int fifo_els_p   = 8,
   parameter  int cnt_width_p  = 16,
   localparam int id_width_lp  = tag_id_width(tag_els_p)
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    en_i,
   input  logic [ctr_width_p-1:0]  ctr_i,
   input  logic                    print_stat_v_i,
   input  logic [data_width_p-1:0] print_stat_tag_i,
   output logic                    v_o,
   input  logic                    ready_i,
   output logic [1:0]              rec_kind_o,
   output logic [id_width_lp-1:0]  rec_id_o,
   output logic [ctr_width_p-1:0]  rec_start_o,
   output logic [ctr_width_p-1:0]  rec_delta_o,
   output logic [tag_els_p-1:0]    active_o,
   output logic [cnt_width_p-1:0]  err_cnt_o,
   output logic [cnt_width_p-1:0]  drop_cnt_o
);

   typedef `BSG_PRINT_STAT_REC_S(ctr_width_p, id_width_lp) rec_s;
   localparam int rec_width_lp = $bits(rec_s);

   logic                   s_v;
   tag_kind_e              s_kind;
   logic [id_width_lp-1:0] s_id;
   logic [ctr_width_p-1:0] s_ts;

   logic [tag_els_p-1:0]   active_r;
   logic [ctr_width_p-1:0] start_r [tag_els_p];
   logic [cnt_width_p-1:0] err_cnt_r, drop_cnt_r;

   logic push_v, err_inc, drop, fifo_ready, s_active;
   rec_s push_rec, pop_rec;

   assign s_active = active_r[s_id];
   assign drop     = push_v & ~fifo_ready;

   // stage 0: capture enabled events with their timestamp
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         s_v    <= 1'b0;
         s_kind <= K_STAT;
         s_id   <= '0;
         s_ts   <= '0;
      end else begin
         s_v <= print_stat_v_i & en_i;
         if (print_stat_v_i & en_i) begin
            s_kind <= tag_kind_e'(print_stat_tag_i[data_width_p-1 -: kind_width_lp]);
            s_id   <= print_stat_tag_i[id_width_lp-1:0];
            s_ts   <= ctr_i;
         end
      end
   end

   // stage 1: decide record and error from the staged event
   always_comb begin
      push_v   = 1'b0;
      err_inc  = 1'b0;
      push_rec = '0;
      if (s_v) begin
         unique case (s_kind)
            K_STAT: begin
               push_v         = 1'b1;
               push_rec.kind  = K_STAT;
               push_rec.id    = s_id;
               push_rec.start = s_ts;
            end
            K_START: err_inc = s_active;
            K_END: begin
               if (s_active) begin
                  push_v         = 1'b1;
                  push_rec.kind  = K_END;
                  push_rec.id    = s_id;
                  push_rec.start = start_r[s_id];
                  push_rec.delta = s_ts - start_r[s_id];
               end else begin
                  err_inc = 1'b1;
               end
            end
            K_RSVD: err_inc = 1'b1;
         endcase
      end
   end

   // stage 1: per-id IDLE/ACTIVE table update
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         active_r <= '0;
         for (int i = 0; i < tag_els_p; i++) start_r[i] <= '0;
      end else if (s_v) begin
         if (s_kind == K_START) begin
            active_r[s_id] <= 1'b1;
            start_r[s_id]  <= s_ts;
         end else if (s_kind == K_END) begin
            active_r[s_id] <= 1'b0;
         end
      end
   end

   // saturating error and drop counters
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         err_cnt_r  <= '0;
         drop_cnt_r <= '0;
      end else begin
         if (err_inc & ~&err_cnt_r)  err_cnt_r  <= err_cnt_r + 1'b1;
         if (drop & ~&drop_cnt_r)    drop_cnt_r <= drop_cnt_r + 1'b1;
      end
   end

   bsg_fifo_1r1w_small #(
      .width_p (rec_width_lp),
      .els_p   (fifo_els_p)
   ) out_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v_i       (push_v),
      .ready_o   (fifo_ready),
      .data_i    (push_rec),
      .v_o       (v_o),
      .data_o    (pop_rec),
      .yumi_i    (v_o & ready_i)
   );

   assign rec_kind_o  = pop_rec.kind;
   assign rec_id_o    = pop_rec.id;
   assign rec_start_o = pop_rec.start;
   assign rec_delta_o = pop_rec.delta;
   assign active_o    = active_r;
   assign err_cnt_o   = err_cnt_r;
   assign drop_cnt_o  = drop_cnt_r;

`ifdef BSG_PRINT_STAT_TRACKER_DISPLAY_EN
   // sim-only trace of pushes, protocol errors and drops
   always @(posedge clk_i) begin
      if (reset_n_i) begin
         if (push_v & fifo_ready)
            $display("[INFO][STAT_TRACKER] %0d %0d %0d %0d",
                     push_rec.kind, push_rec.id, push_rec.start, push_rec.delta);
         if (err_inc)
            $display("[INFO][STAT_TRACKER] protocol error kind=%0d id=%0d",
                     s_kind, s_id);
         if (drop)
            $display("[INFO][STAT_TRACKER] record dropped id=%0d", s_id);
      end
   end
`endif

endmodule

// File: tb/tb_bsg_print_stat_interval_tracker.sv
// Directed bench for bsg_print_stat_interval_tracker.
// Expected records are queued at stimulus time and popped on handshake.
module tb_bsg_print_stat_interval_tracker;

   localparam logic [1:0] KS = 2'b00, KB = 2'b01, KE = 2'b10, KR = 2'b11;

   typedef struct {
      logic [1:0]  kind;
      logic [3:0]  id;
      logic [63:0] start;
      logic [63:0] delta;
   } exp_t;

   logic        clk, reset_n, en, v, ready;
   logic [63:0] ctr;
   logic [31:0] tag;
   logic        v_o;
   logic [1:0]  rec_kind;
   logic [3:0]  rec_id;
   logic [63:0] rec_start, rec_delta;
   logic [15:0] active, err_cnt, drop_cnt;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   bsg_print_stat_interval_tracker dut (
      .clk_i            (clk),
      .reset_n_i        (reset_n),
      .en_i             (en),
      .ctr_i            (ctr),
      .print_stat_v_i   (v),
      .print_stat_tag_i (tag),
      .v_o              (v_o),
      .ready_i          (ready),
      .rec_kind_o       (rec_kind),
      .rec_id_o         (rec_id),
      .rec_start_o      (rec_start),
      .rec_delta_o      (rec_delta),
      .active_o         (active),
      .err_cnt_o        (err_cnt),
      .drop_cnt_o       (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ev(input logic [1:0] k, input int id, input logic [63:0] ts);
      logic [31:0] t;
      t = '0;
      t[31:30] = k;
      t[3:0] = 4'(id);
      v = 1'b1;
      tag = t;
      ctr = ts;
      tick();
   endtask

   task automatic idle(input int n);
      v = 1'b0;
      repeat (n) tick();
   endtask

   task automatic push_exp(input logic [1:0] k, input int id,
                           input logic [63:0] s, input logic [63:0] d);
      exp_t e;
      e.kind = k;
      e.id = 4'(id);
      e.start = s;
      e.delta = d;
      q.push_back(e);
   endtask

   // scoreboard: compare each accepted record against the queue head
   always @(negedge clk) begin
      exp_t e;
      if (reset_n && v_o && ready) begin
         chk("rec_expected", 64'(q.size() > 0), 64'd1);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("rec_kind", 64'(rec_kind), 64'(e.kind));
            chk("rec_id", 64'(rec_id), 64'(e.id));
            chk("rec_start", rec_start, e.start);
            chk("rec_delta", rec_delta, e.delta);
         end
      end
   end

   initial begin
      reset_n = 1'b0;
      en = 1'b1;
      v = 1'b0;
      ready = 1'b1;
      ctr = '0;
      tag = '0;
      #12;
      chk("rst_v_o", 64'(v_o), 0);
      chk("rst_active", 64'(active), 0);
      chk("rst_err", 64'(err_cnt), 0);
      chk("rst_drop", 64'(drop_cnt), 0);
      reset_n = 1'b1;
      tick();

      // basic interval and latency
      push_exp(KE, 3, 100, 250);
      ev(KB, 3, 100);
      ev(KE, 3, 350);
      chk("t1_active3", 64'(active[3]), 1);
      chk("t1_v_o_n1", 64'(v_o), 0);
      idle(1);
      chk("t1_v_o_n2", 64'(v_o), 1);
      chk("t1_idle3", 64'(active[3]), 0);
      idle(2);

      // counter wrap
      push_exp(KE, 5, 64'hFFFF_FFFF_FFFF_FFF6, 15);
      ev(KB, 5, 64'hFFFF_FFFF_FFFF_FFF6);
      ev(KE, 5, 5);
      idle(3);

      // protocol errors
      ev(KE, 7, 0);
      ev(KB, 2, 1000);
      ev(KB, 2, 2000);
      idle(2);
      chk("t3_err", 64'(err_cnt), 2);
      chk("t3_active", 64'(active), 64'h4);
      chk("t3_no_rec", 64'(v_o), 0);
      push_exp(KE, 2, 2000, 500);
      ev(KE, 2, 2500);
      idle(3);
      chk("t3_active0", 64'(active), 0);

      // full FIFO drops, then push with simultaneous pop
      ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (k < 8) push_exp(KS, k, 64'(3000 + k), 0);
         ev(KS, k, 64'(3000 + k));
      end
      idle(2);
      chk("t4_drop", 64'(drop_cnt), 2);
      chk("t4_v_o", 64'(v_o), 1);
      push_exp(KS, 11, 4000, 0);
      ev(KS, 11, 4000);
      v = 1'b0;
      ready = 1'b1;
      tick();
      ready = 1'b0;
      tick();
      chk("t4_no_drop", 64'(drop_cnt), 2);
      ready = 1'b1;
      idle(12);
      chk("t4_drained", 64'(v_o), 0);
      chk("t4_q_empty", 64'(q.size()), 0);

      // disabled tracking ignores events
      en = 1'b0;
      ev(KB, 9, 5000);
      ev(KE, 4, 5001);
      ev(KR, 0, 5002);
      ev(KS, 1, 5003);
      idle(3);
      chk("t5_active", 64'(active), 0);
      chk("t5_err", 64'(err_cnt), 2);
      chk("t5_v_o", 64'(v_o), 0);
      en = 1'b1;

      // async reset mid-operation
      ready = 1'b0;
      for (int k = 0; k < 4; k++) ev(KS, k, 64'(6000 + k));
      ev(KB, 1, 6010);
      idle(2);
      chk("t5_pre_v_o", 64'(v_o), 1);
      chk("t5_pre_active", 64'(active), 64'h2);
      reset_n = 1'b0;
      #2;
      chk("t5_rst_v_o", 64'(v_o), 0);
      chk("t5_rst_active", 64'(active), 0);
      chk("t5_rst_err", 64'(err_cnt), 0);
      chk("t5_rst_drop", 64'(drop_cnt), 0);
      tick();
      reset_n = 1'b1;
      ready = 1'b1;
      idle(2);
      chk("t5_post_v_o", 64'(v_o), 0);

      // back-to-back START/END/START on one id
      push_exp(KE, 0, 10, 10);
      ev(KB, 0, 10);
      ev(KE, 0, 20);
      ev(KB, 0, 30);
      idle(4);
      chk("t6_active", 64'(active), 64'h1);
      chk("t6_err", 64'(err_cnt), 0);
      chk("t6_q_empty", 64'(q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
